// File: rtl/cic_pkg.sv
// CIC shared package: default widths, counter-width helper and settle-count derivation.
// Used by the integrator, down-sampler and comb sections.
// Contents: CIC_DATA_WIDTH, CIC_NR_STAGES, CIC_DIFF_DELAY, clog2(), settle_count().
package cic_pkg;

  // Default data width shared by every CIC section; samples are two's-complement signed.
  localparam int unsigned CIC_DATA_WIDTH = 16;
  localparam int unsigned CIC_NR_STAGES  = 3;
  localparam int unsigned CIC_DIFF_DELAY = 1;

  // Number of bits needed to index 'value' distinct states (ceil(log2(value))).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Enables needed before every stage register and every delay-line tap has seen real data.
  function automatic int unsigned settle_count(input int unsigned nr_stages,
                                               input int unsigned diff_delay);
    return nr_stages * (diff_delay + 1);
  endfunction

endpackage

// File: rtl/cic_comb_chain_if.sv
// Decimated-rate sample bus between the CIC down-sampler and the comb chain.
// Master drives i_ena/i_data and observes o_data/o_valid/o_settled; slave is the comb chain.
// No backpressure: i_ena is a strobe the comb chain must always accept.
interface cic_comb_chain_if
  import cic_pkg::*;
#(
  parameter int unsigned gp_data_width = CIC_DATA_WIDTH
);
  logic                            i_ena;
  logic signed [gp_data_width-1:0] i_data;
  logic signed [gp_data_width-1:0] o_data;
  logic                            o_valid;
  logic                            o_settled;

  modport master (
    output i_ena, i_data,
    input  o_data, o_valid, o_settled
  );

  modport slave (
    input  i_ena, i_data,
    output o_data, o_valid, o_settled
  );
endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb: y[n] = x[n] - x[n-M], M-deep enabled delay line plus registered subtractor.
// Latency: one enable (output register). Backpressure: none, advances only on i_ena.
// Ports: i_clk, i_rst_an (async active-low), i_ena, i_x (stage input), o_y (registered output).
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned gp_data_width = CIC_DATA_WIDTH,
  parameter int unsigned gp_diff_delay = CIC_DIFF_DELAY
) (
  input  logic                            i_clk,
  input  logic                            i_rst_an,
  input  logic                            i_ena,
  input  logic signed [gp_data_width-1:0] i_x,
  output logic signed [gp_data_width-1:0] o_y
);

  logic [gp_diff_delay-1:0][gp_data_width-1:0] dly_q;
  logic signed [gp_data_width-1:0]             y_q;
  logic signed [gp_data_width-1:0]             y_d;

  // Same-width subtraction: wraps modulo 2^W; integrators already absorbed the growth.
  always_comb begin
    y_d = i_x - $signed(dly_q[gp_diff_delay-1]);
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      y_q   <= '0;
      dly_q <= '0;
    end else if (i_ena) begin
      y_q      <= y_d;
      dly_q[0] <= i_x;
      for (int i = 1; i < int'(gp_diff_delay); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign o_y = y_q;

endmodule

// File: rtl/cic_comb_chain.sv
// CIC decimator comb section: N cascaded registered combs at the decimated rate.
// Latency: sample at enable #n appears on o_data after enable #(n+N-1); o_valid one cycle after each enable.
// Backpressure: none; i_ena strobes are always consumed, idle cycles freeze all state.
// Ports: i_clk, i_rst_an (async active-low), bus (slave: i_ena, i_data in; o_data, o_valid, o_settled out).
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int unsigned gp_data_width = CIC_DATA_WIDTH,
  parameter int unsigned gp_nr_stages  = CIC_NR_STAGES,
  parameter int unsigned gp_diff_delay = CIC_DIFF_DELAY
) (
  input  logic             i_clk,
  input  logic             i_rst_an,
  cic_comb_chain_if.slave  bus
);

  localparam int unsigned SettleCnt = settle_count(gp_nr_stages, gp_diff_delay);
  localparam int unsigned CntW      = clog2(SettleCnt + 1);

  // stage_x[k] is the input of stage k; stage_x[N] is the last stage register.
  logic [gp_nr_stages:0][gp_data_width-1:0] stage_x;

  assign stage_x[0] = bus.i_data;

  for (genvar k = 0; k < int'(gp_nr_stages); k++) begin : g_stage
    cic_comb_stage #(
      .gp_data_width (gp_data_width),
      .gp_diff_delay (gp_diff_delay)
    ) u_stage (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_ena    (bus.i_ena),
      .i_x      (stage_x[k]),
      .o_y      (stage_x[k+1])
    );
  end

  assign bus.o_data = stage_x[gp_nr_stages];

  logic            valid_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            settled_q;
  logic            settled_d;

  // Counter saturates at C; settled looks at the next count so it rises with the C-th enable.
  always_comb begin
    cnt_d     = cnt_q;
    settled_d = settled_q;
    if (bus.i_ena && (cnt_q != CntW'(SettleCnt))) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (cnt_d == CntW'(SettleCnt)) begin
      settled_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      settled_q <= 1'b0;
    end else begin
      valid_q   <= bus.i_ena;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_settled = settled_q;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: three configurations (N3M1W16, N1M2W16, N1M1W8) against a
// transfer-function reference model (output = sum of C(N,j)*(-1)^j * x[n-N+1-jM] mod 2^W).
// Directed impulse/step/wrap/gating/reset cases plus randomized data and enables.
module tb_cic_comb_chain;

  logic clk;
  logic rst_an;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cic_comb_chain_if #(.gp_data_width(16)) ifa ();
  cic_comb_chain_if #(.gp_data_width(16)) ifb ();
  cic_comb_chain_if #(.gp_data_width(8))  ifc ();

  cic_comb_chain #(.gp_data_width(16), .gp_nr_stages(3), .gp_diff_delay(1)) u_a (
    .i_clk(clk), .i_rst_an(rst_an), .bus(ifa)
  );
  cic_comb_chain #(.gp_data_width(16), .gp_nr_stages(1), .gp_diff_delay(2)) u_b (
    .i_clk(clk), .i_rst_an(rst_an), .bus(ifb)
  );
  cic_comb_chain #(.gp_data_width(8), .gp_nr_stages(1), .gp_diff_delay(1)) u_c (
    .i_clk(clk), .i_rst_an(rst_an), .bus(ifc)
  );

  int n_checks = 0;
  int n_err    = 0;

  int nn [3] = '{3, 1, 1};
  int mm [3] = '{1, 2, 1};
  int ww [3] = '{16, 16, 8};

  int hist_a[$];
  int hist_b[$];
  int hist_c[$];
  int en_cnt [3];

  logic signed [31:0] last_d;
  logic signed [31:0] last_v;
  logic signed [31:0] last_s;

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  // Output after enable e of an N-stage, delay-M comb: (1 - z^-M)^N applied to the sample
  // history, delayed by N-1 enables, reduced to a W-bit signed value.
  function automatic int model_out(input int hist[$], input int e, input int n,
                                   input int m, input int w);
    longint s;
    longint v;
    int     idx;
    s = 0;
    for (int j = 0; j <= n; j++) begin
      idx = e - n + 1 - j * m;
      if (idx >= 1) begin
        if (j % 2 == 0) s = s + binom(n, j) * hist[idx-1];
        else            s = s - binom(n, j) * hist[idx-1];
      end
    end
    v = s & ((64'sd1 <<< w) - 1);
    if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
    return int'(v);
  endfunction

  function automatic int rnd_sample(input int d);
    return int'($urandom_range(0, (1 << ww[d]) - 1)) - (1 << (ww[d] - 1));
  endfunction

  task automatic clear_models();
    hist_a.delete();
    hist_b.delete();
    hist_c.delete();
    for (int d = 0; d < 3; d++) en_cnt[d] = 0;
  endtask

  // One clock on DUT d: drive, clock, sample 1 time unit later, compare with the model.
  task automatic step(input int d, input bit ena, input int din);
    int hq[$];
    int c_settle;
    case (d)
      0: begin ifa.i_ena = ena; ifa.i_data = 16'(din); end
      1: begin ifb.i_ena = ena; ifb.i_data = 16'(din); end
      default: begin ifc.i_ena = ena; ifc.i_data = 8'(din); end
    endcase
    @(posedge clk);
    #1;
    if (ena) begin
      case (d)
        0: hist_a.push_back(din);
        1: hist_b.push_back(din);
        default: hist_c.push_back(din);
      endcase
      en_cnt[d]++;
    end
    case (d)
      0: begin hq = hist_a; last_d = $signed(ifa.o_data); last_v = 32'(ifa.o_valid); last_s = 32'(ifa.o_settled); end
      1: begin hq = hist_b; last_d = $signed(ifb.o_data); last_v = 32'(ifb.o_valid); last_s = 32'(ifb.o_settled); end
      default: begin hq = hist_c; last_d = $signed(ifc.o_data); last_v = 32'(ifc.o_valid); last_s = 32'(ifc.o_settled); end
    endcase
    c_settle = nn[d] * (mm[d] + 1);
    check($sformatf("d%0d_valid", d), last_v, int'(ena));
    check($sformatf("d%0d_data", d), last_d, model_out(hq, en_cnt[d], nn[d], mm[d], ww[d]));
    check($sformatf("d%0d_settled", d), last_s, int'(en_cnt[d] >= c_settle));
    case (d)
      0: ifa.i_ena = 1'b0;
      1: ifb.i_ena = 1'b0;
      default: ifc.i_ena = 1'b0;
    endcase
  endtask

  int ka_imp  [7] = '{0, 0, 1, -3, 3, -1, 0};
  int ka_step [7] = '{0, 0, 100, -200, 100, 0, 0};
  int kb_imp  [4] = '{1, 0, -1, 0};
  int kc_wrap [2] = '{127, 1};

  initial begin
    int k;
    rst_an = 1'b0;
    ifa.i_ena = 1'b0; ifa.i_data = '0;
    ifb.i_ena = 1'b0; ifb.i_data = '0;
    ifc.i_ena = 1'b0; ifc.i_data = '0;
    clear_models();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_data", $signed(ifa.o_data), 0);
    check("rst_a_valid", 32'(ifa.o_valid), 0);
    check("rst_a_settled", 32'(ifa.o_settled), 0);
    check("rst_b_data", $signed(ifb.o_data), 0);
    check("rst_c_data", $signed(ifc.o_data), 0);
    rst_an = 1'b1;

    // Impulse, continuous enable, N=3 M=1.
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b1, (i == 0) ? 1 : 0);
      if (i < 7) check("a_imp_known", last_d, ka_imp[i]);
    end

    // Step of 100 from a flushed (all-zero) state.
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, 100);
      if (i < 7) check("a_step_known", last_d, ka_step[i]);
    end
    for (int i = 0; i < 8; i++) step(0, 1'b1, 0);

    // Differential delay M=2.
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, (i == 0) ? 1 : 0);
      if (i < 4) check("b_imp_known", last_d, kb_imp[i]);
    end

    // 8-bit wrap-around.
    step(2, 1'b1, 127);
    check("c_wrap0_known", last_d, kc_wrap[0]);
    step(2, 1'b1, -128);
    check("c_wrap1_known", last_d, kc_wrap[1]);

    // Randomized data and enable density on every configuration.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 150; i++) begin
        step(d, ($urandom_range(0, 3) != 0), rnd_sample(d));
      end
    end

    // Mid-stream asynchronous reset on the settled N=3 chain.
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1000 + i);
    ifa.i_ena = 1'b1;
    ifa.i_data = 16'd55;
    #3;
    rst_an = 1'b0;
    #1;
    check("amid_rst_data", $signed(ifa.o_data), 0);
    check("amid_rst_valid", 32'(ifa.o_valid), 0);
    check("amid_rst_settled", 32'(ifa.o_settled), 0);
    ifa.i_ena = 1'b0;
    clear_models();
    @(posedge clk);
    #1;
    rst_an = 1'b1;

    // Gated impulse after reset: one enable every fourth cycle; settle count ignores idle cycles.
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) begin
        step(0, 1'b1, (k == 0) ? 1 : 0);
        if (k < 7) check("a_gated_known", last_d, ka_imp[k]);
        k++;
      end else begin
        step(0, 1'b0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
